// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the BytePipe register protocol, used by both the
// host-side initiator (bp_reg_initiator) and the register target (bpReg).
//   bp_state_e   : initiator transaction states
//   BP_WR_BIT    : command-byte bit that marks a write
//   BP_ADDR_MSK  : command-byte bits that carry the register address
//   bp_cmd_byte  : builds a command byte from a write flag and an address
// -----------------------------------------------------------------------------
package bp_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEND_ADDR = 3'd1,
      SEND_DATA = 3'd2,
      WAIT_RSP  = 3'd3,
      RESPOND   = 3'd4
   } bp_state_e;

   localparam int         BP_WR_BIT   = 7;
   localparam logic [7:0] BP_ADDR_MSK = 8'h7f;

   // Address bits outside the mask are discarded so a wide address can never
   // corrupt the write flag.
   function automatic logic [7:0] bp_cmd_byte(input logic wr, input logic [7:0] addr);
      logic [7:0] b;
      b            = addr & BP_ADDR_MSK;
      b[BP_WR_BIT] = wr;
      return b;
   endfunction

endpackage

// File: rtl/bp_reg_initiator.sv
// -----------------------------------------------------------------------------
// bp_reg_initiator
// Host-side initiator for the BytePipe register protocol. A single register
// read or write request is turned into a command byte ({write, addr}) plus,
// for writes, a data byte. The one-byte reply from the target (the register
// value before this request) is returned on the response port, or a zero with
// a timeout flag if the target stays silent for TIMEOUT enabled cycles.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_cg                clock gate: when low no transfer completes, state holds
//   i_req_*/o_req_ready request channel (ready only in IDLE)
//   o_rsp_*/i_rsp_ready response channel, held until accepted
//   o_bp_data/valid     BytePipe toward the target, i_bp_ready its ready
//   i_bp_data/valid     BytePipe from the target, o_bp_ready its ready
//   o_busy              high whenever a transaction is in flight
// All outputs are registered.
// -----------------------------------------------------------------------------
module bp_reg_initiator
   import bp_pkg::*;
#(
   parameter int ADDR_W    = 7,
   parameter int TIMEOUT_W = 16,
   parameter int TIMEOUT   = 1000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cg,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_write,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [7:0]        i_req_wrdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [7:0]        o_rsp_data,
   output logic              o_rsp_timeout,
   output logic [7:0]        o_bp_data,
   output logic              o_bp_valid,
   input  logic              i_bp_ready,
   input  logic [7:0]        i_bp_data,
   input  logic              i_bp_valid,
   output logic              o_bp_ready,
   output logic              o_busy
);

   // The command byte is {write, addr}, so the address must fill exactly 7 bits.
   if (ADDR_W + 1 != 8) begin : g_bad_addr_w
      $error("bp_reg_initiator: ADDR_W+1 must equal 8");
   end
   if (TIMEOUT < 0 || TIMEOUT >= (2 ** TIMEOUT_W)) begin : g_bad_timeout
      $error("bp_reg_initiator: TIMEOUT does not fit in TIMEOUT_W bits");
   end

   localparam bit                   TO_EN   = (TIMEOUT > 0);
   localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   bp_state_e            state_q, state_d;
   logic                 wr_q, wr_d;
   logic [7:0]           wrdata_q, wrdata_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic                 req_ready_q, req_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [7:0]           rsp_data_q, rsp_data_d;
   logic                 rsp_timeout_q, rsp_timeout_d;
   logic [7:0]           bp_data_q, bp_data_d;
   logic                 bp_valid_q, bp_valid_d;
   logic                 bp_ready_q, bp_ready_d;
   logic                 busy_q, busy_d;

   logic req_xfer_s, bp_out_xfer_s, bp_in_xfer_s, rsp_xfer_s, timeout_hit_s;

   // Handshake qualifiers: a transfer needs valid, ready and an enabled cycle.
   always_comb begin
      req_xfer_s    = i_req_valid & req_ready_q & i_cg;
      bp_out_xfer_s = bp_valid_q  & i_bp_ready  & i_cg;
      bp_in_xfer_s  = i_bp_valid  & bp_ready_q  & i_cg;
      rsp_xfer_s    = rsp_valid_q & i_rsp_ready & i_cg;
      timeout_hit_s = TO_EN && (cnt_q == TO_LAST);
   end

   // Next-state and next-output logic; every output is computed for the
   // cycle after the transition so the registered outputs track the state.
   always_comb begin
      state_d       = state_q;
      wr_d          = wr_q;
      wrdata_d      = wrdata_q;
      cnt_d         = cnt_q;
      req_ready_d   = req_ready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_timeout_d = rsp_timeout_q;
      bp_data_d     = bp_data_q;
      bp_valid_d    = bp_valid_q;
      bp_ready_d    = bp_ready_q;
      busy_d        = busy_q;

      case (state_q)
         IDLE: begin
            // o_bp_ready stays high here, so stray target bytes are silently
            // drained and never reach the response port.
            if (req_xfer_s) begin
               state_d     = SEND_ADDR;
               wr_d        = i_req_write;
               wrdata_d    = i_req_wrdata;
               bp_data_d   = bp_cmd_byte(i_req_write, 8'(i_req_addr));
               bp_valid_d  = 1'b1;
               bp_ready_d  = 1'b0;
               req_ready_d = 1'b0;
               busy_d      = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         SEND_ADDR: begin
            if (bp_out_xfer_s && wr_q) begin
               state_d   = SEND_DATA;
               bp_data_d = wrdata_q;
            end else if (bp_out_xfer_s) begin
               state_d    = WAIT_RSP;
               bp_valid_d = 1'b0;
               bp_ready_d = 1'b1;
               cnt_d      = '0;
            end else begin
               state_d = SEND_ADDR;
            end
         end

         SEND_DATA: begin
            if (bp_out_xfer_s) begin
               state_d    = WAIT_RSP;
               bp_valid_d = 1'b0;
               bp_ready_d = 1'b1;
               cnt_d      = '0;
            end else begin
               state_d = SEND_DATA;
            end
         end

         WAIT_RSP: begin
            // A byte arriving on the last allowed cycle beats the timeout.
            if (bp_in_xfer_s) begin
               state_d       = RESPOND;
               rsp_data_d    = i_bp_data;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               bp_ready_d    = 1'b0;
            end else if (i_cg && timeout_hit_s) begin
               state_d       = RESPOND;
               rsp_data_d    = 8'h00;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               bp_ready_d    = 1'b0;
            end else if (i_cg) begin
               cnt_d = cnt_q + TIMEOUT_W'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end

         RESPOND: begin
            if (rsp_xfer_s) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               bp_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end else begin
               state_d = RESPOND;
            end
         end

         default: begin
            state_d       = IDLE;
            cnt_d         = '0;
            req_ready_d   = 1'b1;
            rsp_valid_d   = 1'b0;
            rsp_data_d    = 8'h00;
            rsp_timeout_d = 1'b0;
            bp_data_d     = 8'h00;
            bp_valid_d    = 1'b0;
            bp_ready_d    = 1'b1;
            busy_d        = 1'b0;
         end
      endcase
   end

   // State, request latch, timeout counter and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q       <= IDLE;
         wr_q          <= 1'b0;
         wrdata_q      <= 8'h00;
         cnt_q         <= '0;
         req_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= 8'h00;
         rsp_timeout_q <= 1'b0;
         bp_data_q     <= 8'h00;
         bp_valid_q    <= 1'b0;
         bp_ready_q    <= 1'b1;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_q          <= wr_d;
         wrdata_q      <= wrdata_d;
         cnt_q         <= cnt_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_timeout_q <= rsp_timeout_d;
         bp_data_q     <= bp_data_d;
         bp_valid_q    <= bp_valid_d;
         bp_ready_q    <= bp_ready_d;
         busy_q        <= busy_d;
      end
   end

   assign o_req_ready   = req_ready_q;
   assign o_rsp_valid   = rsp_valid_q;
   assign o_rsp_data    = rsp_data_q;
   assign o_rsp_timeout = rsp_timeout_q;
   assign o_bp_data     = bp_data_q;
   assign o_bp_valid    = bp_valid_q;
   assign o_bp_ready    = bp_ready_q;
   assign o_busy        = busy_q;

endmodule

// File: tb/tb_bp_reg_initiator.sv
// -----------------------------------------------------------------------------
// tb_bp_reg_initiator
// Directed bench for bp_reg_initiator (TIMEOUT=8) with a behavioural bpReg
// target and a separate reference register model.
// -----------------------------------------------------------------------------
module tb_bp_reg_initiator;

   logic       clk;
   logic       rst_n, cg;
   logic       req_valid, req_write;
   logic [6:0] req_addr;
   logic [7:0] req_wrdata;
   logic       rsp_rdy, bp_rdy;
   logic [7:0] bp_in_data;
   logic       bp_in_valid;
   logic       req_ready, rsp_valid, rsp_timeout, bp_valid, bp_ready_o, busy;
   logic [7:0] rsp_data, bp_data;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cyc  = 0;
   bit rnd      = 1'b0;

   // behavioural target state
   logic [7:0] tgt_regs [128];
   logic [7:0] ref_regs [128];
   bit         tgt_have, tgt_pend, tgt_silent;
   logic [7:0] tgt_cmd, tgt_byte;
   int         tgt_cnt, tgt_delay;
   logic [7:0] sent_q [$];

   localparam logic [21:0] RST_VEC = {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

   bp_reg_initiator #(.ADDR_W(7), .TIMEOUT_W(16), .TIMEOUT(8)) dut (
      .i_clk         (clk),
      .i_rst         (rst_n),
      .i_cg          (cg),
      .i_req_valid   (req_valid),
      .o_req_ready   (req_ready),
      .i_req_write   (req_write),
      .i_req_addr    (req_addr),
      .i_req_wrdata  (req_wrdata),
      .o_rsp_valid   (rsp_valid),
      .i_rsp_ready   (rsp_rdy),
      .o_rsp_data    (rsp_data),
      .o_rsp_timeout (rsp_timeout),
      .o_bp_data     (bp_data),
      .o_bp_valid    (bp_valid),
      .i_bp_ready    (bp_rdy),
      .i_bp_data     (bp_in_data),
      .i_bp_valid    (bp_in_valid),
      .o_bp_ready    (bp_ready_o),
      .o_busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [21:0] outvec();
      return {req_ready, rsp_valid, rsp_data, rsp_timeout, bp_data, bp_valid, bp_ready_o, busy};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic bound_fail(input string tag);
      n_assert++;
      n_fail++;
      $error("FAIL %s: wait bound expired", tag);
   endtask

   task automatic tgt_respond(input logic [7:0] val);
      if (!tgt_silent) begin
         tgt_pend = 1'b1;
         tgt_cnt  = tgt_delay;
         tgt_byte = val;
      end
   endtask

   // One clock: record pre-edge handshakes, step, check hold/stall stability,
   // advance the target model, optionally randomise the flow-control inputs.
   task automatic tick();
      bit         x_out, x_in, stall_bp, stall_rsp, hold, cg0;
      logic [7:0] d_out;
      logic [21:0] v0;
      logic [8:0] bp0;
      logic [9:0] rsp0;
      x_out     = bp_valid && bp_rdy && cg;
      d_out     = bp_data;
      x_in      = bp_in_valid && bp_ready_o && cg;
      stall_bp  = bp_valid && !(bp_rdy && cg);
      stall_rsp = rsp_valid && !(rsp_rdy && cg);
      hold      = !cg;
      cg0       = cg;
      v0        = outvec();
      bp0       = {bp_valid, bp_data};
      rsp0      = {rsp_valid, rsp_timeout, rsp_data};
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (rst_n) begin
         if (hold)      chk("cg_hold", outvec(), v0);
         if (stall_bp)  chk("bp_stall_stable", {bp_valid, bp_data}, bp0);
         if (stall_rsp) chk("rsp_stall_stable", {rsp_valid, rsp_timeout, rsp_data}, rsp0);
      end
      if (x_in) tgt_pend = 1'b0;
      if (tgt_pend && tgt_cnt > 0 && cg0) tgt_cnt--;
      if (x_out) begin
         sent_q.push_back(d_out);
         if (!tgt_have && d_out[7]) begin
            tgt_have = 1'b1;
            tgt_cmd  = d_out;
         end else if (!tgt_have) begin
            tgt_respond(tgt_regs[d_out[6:0]]);
         end else begin
            tgt_respond(tgt_regs[tgt_cmd[6:0]]);
            tgt_regs[tgt_cmd[6:0]] = d_out;
            tgt_have = 1'b0;
         end
      end
      bp_in_valid = tgt_pend && (tgt_cnt == 0);
      bp_in_data  = tgt_byte;
      if (rnd) begin
         cg      = ($urandom_range(0, 99) != 0);
         bp_rdy  = 1'($urandom_range(0, 1));
         rsp_rdy = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic send_req(input logic wr, input logic [6:0] a, input logic [7:0] d);
      int n;
      n = 0;
      req_valid  = 1'b1;
      req_write  = wr;
      req_addr   = a;
      req_wrdata = d;
      while (!(req_ready && cg) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) bound_fail("req_accept");
      acc_cyc = cyc;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output logic [7:0] rd, output logic to, output int lat);
      int n;
      n = 0;
      while (!rsp_valid && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) bound_fail("rsp_wait");
      lat = cyc - acc_cyc;
      rd  = rsp_data;
      to  = rsp_timeout;
   endtask

   task automatic accept_rsp();
      int n;
      n = 0;
      while (!(rsp_valid && rsp_rdy && cg) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) bound_fail("rsp_accept");
      tick();
   endtask

   task automatic do_req(input logic wr, input logic [6:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output logic to, output int lat);
      send_req(wr, a, d);
      wait_rsp(rd, to, lat);
      accept_rsp();
   endtask

   initial begin
      logic [7:0] rd, exp_d, d;
      logic       to, wr;
      logic [6:0] a;
      int         lat;
      bit         seen;

      rst_n = 1'b0; cg = 1'b1; bp_rdy = 1'b1; rsp_rdy = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 7'd0; req_wrdata = 8'h00;
      bp_in_valid = 1'b0; bp_in_data = 8'h00;
      tgt_have = 1'b0; tgt_pend = 1'b0; tgt_silent = 1'b0;
      tgt_cmd = 8'h00; tgt_byte = 8'h00; tgt_cnt = 0; tgt_delay = 0;
      for (int i = 0; i < 128; i++) begin
         tgt_regs[i] = 8'((i * 7) + 1);
         ref_regs[i] = 8'((i * 7) + 1);
      end
      tgt_regs[3] = 8'h11;
      ref_regs[3] = 8'h11;

      // reset state
      repeat (3) @(negedge clk);
      chk("reset_state", outvec(), RST_VEC);
      rst_n = 1'b1;
      tick();
      chk("idle_after_reset", outvec(), RST_VEC);

      // 1: write 0x5a to 0x03, target returns old value 0x11
      sent_q.delete();
      do_req(1'b1, 7'h03, 8'h5a, rd, to, lat);
      chk("t1_data", rd, 8'h11);
      chk("t1_timeout", to, 1'b0);
      chk("t1_latency", lat, 4);
      chk("t1_bytes", {8'(sent_q.size()), sent_q[0], sent_q[1]}, {8'd2, 8'h83, 8'h5a});
      chk("t1_back_idle", {req_ready, rsp_valid, busy, bp_ready_o}, 4'b1001);
      ref_regs[3] = 8'h5a;

      // 2: read back 0x03
      sent_q.delete();
      do_req(1'b0, 7'h03, 8'h00, rd, to, lat);
      chk("t2_data", rd, 8'h5a);
      chk("t2_timeout", to, 1'b0);
      chk("t2_latency", lat, 3);
      chk("t2_bytes", {8'(sent_q.size()), sent_q[0]}, {8'd1, 8'h03});

      // 3: silent target -> timeout 8 cycles after WAIT_RSP entry
      tgt_silent = 1'b1;
      do_req(1'b0, 7'h05, 8'h00, rd, to, lat);
      chk("t3_data", rd, 8'h00);
      chk("t3_timeout", to, 1'b1);
      chk("t3_latency", lat, 10);
      // late 0x77 drained in IDLE, never answered
      tgt_pend = 1'b1; tgt_cnt = 0; tgt_byte = 8'h77;
      bp_in_valid = 1'b1; bp_in_data = 8'h77;
      seen = 1'b0;
      repeat (5) begin
         tick();
         if (rsp_valid || busy) seen = 1'b1;
      end
      chk("t3_no_stray_rsp", seen, 1'b0);
      chk("t3_stray_drained", tgt_pend, 1'b0);

      // clock gate low during WAIT_RSP freezes the timeout counter
      send_req(1'b0, 7'h09, 8'h00);
      repeat (3) tick();
      cg = 1'b0;
      repeat (20) tick();
      chk("cg_wait_frozen", {rsp_valid, busy, bp_ready_o}, 3'b011);
      cg = 1'b1;
      wait_rsp(rd, to, lat);
      chk("cg_timeout", to, 1'b1);
      chk("cg_latency", lat, 30);
      accept_rsp();

      // 6: byte lands on the exact timeout cycle -> data wins
      tgt_silent = 1'b0;
      tgt_delay  = 7;
      do_req(1'b0, 7'h03, 8'h00, rd, to, lat);
      chk("t6_data", rd, 8'h5a);
      chk("t6_timeout", to, 1'b0);
      chk("t6_latency", lat, 10);
      tgt_delay = 0;

      // 5: async reset during SEND_DATA
      send_req(1'b1, 7'h03, 8'hc3);
      tick();
      bp_rdy = 1'b0;
      chk("t5_send_data", {bp_valid, bp_data, busy}, {1'b1, 8'hc3, 1'b1});
      #2 rst_n = 1'b0;
      #1 chk("t5_async_reset", outvec(), RST_VEC);
      tgt_have = 1'b0; tgt_pend = 1'b0; bp_in_valid = 1'b0;
      tick();
      rst_n  = 1'b1;
      bp_rdy = 1'b1;
      tick();
      do_req(1'b0, 7'h03, 8'h00, rd, to, lat);
      chk("t5_read_data", rd, 8'h5a);
      chk("t5_read_latency", lat, 3);

      // 4: random traffic with flow-control stalls and gate drops
      rnd = 1'b1;
      for (int k = 0; k < 500; k++) begin
         wr        = 1'($urandom_range(0, 1));
         a         = 7'($urandom_range(0, 127));
         d         = 8'($urandom);
         tgt_delay = $urandom_range(0, 3);
         exp_d     = ref_regs[a];
         if (wr) ref_regs[a] = d;
         sent_q.delete();
         do_req(wr, a, d, rd, to, lat);
         chk("rnd_rsp", {to, rd}, {1'b0, exp_d});
         chk("rnd_cmd", sent_q[0], {wr, a});
      end
      rnd = 1'b0;
      cg = 1'b1; bp_rdy = 1'b1; rsp_rdy = 1'b1;
      tick();
      chk("final_idle", {req_ready, rsp_valid, busy}, 3'b100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
